// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared widths and FSM state type for the SDRAM write arbiter
package sd_arb_pkg;
    localparam int SD_ADDR_W = 28;
    localparam int SD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/sd_write_arbiter_if.sv
// rtl/sd_write_arbiter_if.sv - requester and SDRAM write-port signals of the arbiter
interface sd_write_arbiter_if #(parameter int NUM_REQ = 2);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                       req;
    logic [NUM_REQ*sd_arb_pkg::SD_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*sd_arb_pkg::SD_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]                       ack;
    logic [IDX_W-1:0]                         grant_idx;
    logic                                     busy;
    logic                                     SD_write;
    logic [sd_arb_pkg::SD_ADDR_W-1:0]         SD_address;
    logic [sd_arb_pkg::SD_DATA_W-1:0]         SD_wdata;
    logic                                     SD_waitrequest;

    modport master (
        output req, req_addr, req_wdata, SD_waitrequest,
        input  ack, grant_idx, busy, SD_write, SD_address, SD_wdata
    );

    modport slave (
        input  req, req_addr, req_wdata, SD_waitrequest,
        output ack, grant_idx, busy, SD_write, SD_address, SD_wdata
    );
endinterface

// File: rtl/sd_rr_pick.sv
// rtl/sd_rr_pick.sv - combinational winner picker; SD_ARB_FIXED_PRIO_EN selects fixed priority
module sd_rr_pick #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);
`ifdef SD_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end
`else
    // Scan offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
                    valid  = 1'b1;
                    winner = IDX_W'(i);
                end
            end
        end
    end
`endif
endmodule

// File: rtl/sd_write_arbiter.sv
// rtl/sd_write_arbiter.sv - grants one single-word SDRAM write at a time to NUM_REQ requesters
// (SD_ARB_FIXED_PRIO_EN switches the picker to fixed priority)
module sd_write_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    sd_write_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic                 sd_write_q, sd_write_d;
    logic [SD_ADDR_W-1:0] sd_address_q, sd_address_d;
    logic [SD_DATA_W-1:0] sd_wdata_q, sd_wdata_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic                 busy_q, busy_d;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [SD_ADDR_W-1:0] pick_addr;
    logic [SD_DATA_W-1:0] pick_data;

    // grant_idx_q only moves on entry to WRITE, so it doubles as the round-robin pointer.
    sd_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req),
        .last_grant (grant_idx_q),
        .valid      (pick_valid),
        .winner     (pick_idx)
    );

    always_comb begin
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_addr = bus.req_addr[i*SD_ADDR_W +: SD_ADDR_W];
                pick_data = bus.req_wdata[i*SD_DATA_W +: SD_DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sd_write_d   = sd_write_q;
        sd_address_d = sd_address_q;
        sd_wdata_d   = sd_wdata_q;
        ack_d        = '0;
        grant_idx_d  = grant_idx_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = WRITE;
                    sd_write_d   = 1'b1;
                    sd_address_d = pick_addr;
                    sd_wdata_d   = pick_data;
                    grant_idx_d  = pick_idx;
                    busy_d       = 1'b1;
                end
            end
            WRITE: begin
                if (!bus.SD_waitrequest) begin
                    state_d    = ACK;
                    sd_write_d = 1'b0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_idx_q == IDX_W'(i)) ack_d[i] = 1'b1;
                    end
                end
            end
            // The acked requester may still show req here, so no arbitration in ACK.
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                sd_write_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sd_write_q   <= 1'b0;
            sd_address_q <= '0;
            sd_wdata_q   <= '0;
            ack_q        <= '0;
            grant_idx_q  <= IDX_W'(NUM_REQ - 1);
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sd_write_q   <= sd_write_d;
            sd_address_q <= sd_address_d;
            sd_wdata_q   <= sd_wdata_d;
            ack_q        <= ack_d;
            grant_idx_q  <= grant_idx_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.SD_write   = sd_write_q;
    assign bus.SD_address = sd_address_q;
    assign bus.SD_wdata   = sd_wdata_q;
    assign bus.ack        = ack_q;
    assign bus.grant_idx  = grant_idx_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sd_write_arbiter.sv
// tb/tb_sd_write_arbiter.sv - randomized self-checking bench for sd_write_arbiter (2- and 3-requester builds)
module tb_sd_write_arbiter;
    import sd_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_write_arbiter_if #(.NUM_REQ(2)) if2 ();
    sd_write_arbiter_if #(.NUM_REQ(3)) if3 ();

    sd_write_arbiter #(.NUM_REQ(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
    sd_write_arbiter #(.NUM_REQ(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last2, last3;

    always @(posedge clk) cyc++;

    // Reference arbitration rule: first requester at or after last+1 (wrapping), or lowest index.
    function automatic int model_pick(int last, int mask, int n);
`ifdef SD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < n; i++) if (mask[i]) return i;
`else
        for (int k = 1; k <= n; k++) if (mask[(last + k) % n]) return (last + k) % n;
`endif
        return -1;
    endfunction

    task automatic wait_write(input int which, output bit seen);
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            if (which == 2 && if2.SD_write === 1'b1) seen = 1'b1;
            if (which == 3 && if3.SD_write === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if2.req = '0; if2.req_addr = '0; if2.req_wdata = '0; if2.SD_waitrequest = 1'b0;
        if3.req = '0; if3.req_addr = '0; if3.req_wdata = '0; if3.SD_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({if2.SD_write, if2.SD_address, if2.SD_wdata, if2.ack, if2.busy} !== '0)
            $display("FAIL reset_outputs2: got %b/%h/%h/%b/%b required all zero", if2.SD_write, if2.SD_address, if2.SD_wdata, if2.ack, if2.busy);
        else n_pass++;
        n_total++;
        if (if2.grant_idx !== 1'd1) $display("FAIL reset_grant2: got %0d required 1", if2.grant_idx);
        else n_pass++;
        n_total++;
        if ({if3.SD_write, if3.SD_address, if3.SD_wdata, if3.ack, if3.busy} !== '0)
            $display("FAIL reset_outputs3: got %b/%h/%h/%b/%b required all zero", if3.SD_write, if3.SD_address, if3.SD_wdata, if3.ack, if3.busy);
        else n_pass++;
        n_total++;
        if (if3.grant_idx !== 2'd2) $display("FAIL reset_grant3: got %0d required 2", if3.grant_idx);
        else n_pass++;
        reset = 1'b1;
        last2 = 1; last3 = 2;
        @(negedge clk);
    endtask

    task automatic test_single();
        int exp;
        if2.req_addr[27:0]   = 28'h0000100;
        if2.req_wdata[31:0]  = 32'hDEADBEEF;
        if2.SD_waitrequest   = 1'b0;
        if2.req              = 2'b01;
        exp = model_pick(last2, 1, 2);
        @(negedge clk);
        n_total++;
        if (if2.SD_write !== 1'b1 || if2.busy !== 1'b1)
            $display("FAIL single_strobe: write=%b busy=%b required 1/1", if2.SD_write, if2.busy);
        else n_pass++;
        n_total++;
        if (if2.SD_address !== 28'h0000100 || if2.SD_wdata !== 32'hDEADBEEF)
            $display("FAIL single_payload: got %h/%h required 0000100/deadbeef", if2.SD_address, if2.SD_wdata);
        else n_pass++;
        n_total++;
        if (int'(if2.grant_idx) != exp) $display("FAIL single_grant: got %0d required %0d", if2.grant_idx, exp);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (if2.ack !== 2'b01 || if2.SD_write !== 1'b0)
            $display("FAIL single_ack: ack=%b write=%b required 01/0", if2.ack, if2.SD_write);
        else n_pass++;
        if2.req = '0;
        last2 = exp;
        @(negedge clk);
        n_total++;
        if (if2.busy !== 1'b0 || if2.ack !== 2'b00)
            $display("FAIL single_idle: busy=%b ack=%b required 0/00", if2.busy, if2.ack);
        else n_pass++;
    endtask

    task automatic test_alternate();
        int exp, prev;
        bit seen;
        prev = 0;
        for (int i = 0; i < 2; i++) begin
            if2.req_addr[i*28 +: 28] = 28'($urandom);
            if2.req_wdata[i*32 +: 32] = $urandom;
        end
        if2.SD_waitrequest = 1'b0;
        if2.req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_write(2, seen);
            n_total++;
            if (!seen) begin $display("FAIL alt_timeout: no SD_write within 10 cycles"); return; end
            n_pass++;
            exp = model_pick(last2, 3, 2);
            n_total++;
            if (int'(if2.grant_idx) != exp || if2.SD_address !== if2.req_addr[exp*28 +: 28] || if2.SD_wdata !== if2.req_wdata[exp*32 +: 32])
                $display("FAIL alt_grant: got idx %0d addr %h data %h required idx %0d", if2.grant_idx, if2.SD_address, if2.SD_wdata, exp);
            else n_pass++;
            if (t > 0) begin
                n_total++;
                if (cyc - prev != 3) $display("FAIL alt_period: got %0d cycles required 3", cyc - prev);
                else n_pass++;
            end
            prev = cyc;
            @(negedge clk);
            n_total++;
            if (int'(if2.ack) != (1 << exp)) $display("FAIL alt_ack: got %b required %0d", if2.ack, 1 << exp);
            else n_pass++;
            last2 = exp;
            if2.req_addr[exp*28 +: 28] = 28'($urandom);
            if2.req_wdata[exp*32 +: 32] = $urandom;
        end
        if2.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        int exp, acks;
        bit seen;
        logic [27:0] a;
        logic [31:0] d;
        a = 28'($urandom); d = $urandom;
        if2.req_addr[27:0] = a; if2.req_wdata[31:0] = d;
        if2.SD_waitrequest = 1'b1;
        if2.req = 2'b01;
        exp = model_pick(last2, 1, 2);
        acks = 0;
        wait_write(2, seen);
        n_total++;
        if (!seen) begin $display("FAIL stall_timeout: no SD_write within 10 cycles"); return; end
        n_pass++;
        for (int k = 1; k <= 6; k++) begin
            n_total++;
            if (if2.SD_write !== 1'b1 || if2.SD_address !== a || if2.SD_wdata !== d)
                $display("FAIL stall_hold: cycle %0d write=%b addr=%h data=%h required 1/%h/%h", k, if2.SD_write, if2.SD_address, if2.SD_wdata, a, d);
            else n_pass++;
            if (if2.ack !== 2'b00) acks++;
            if (k == 6) if2.SD_waitrequest = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (if2.ack !== 2'b01) $display("FAIL stall_ack: got %b required 01", if2.ack);
        else n_pass++;
        if2.req = '0;
        for (int r = 0; r < 4; r++) begin
            if (if2.ack !== 2'b00) acks++;
            @(negedge clk);
        end
        n_total++;
        if (acks != 1) $display("FAIL stall_ack_count: got %0d required 1", acks);
        else n_pass++;
        last2 = exp;
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        int acks;
        if2.SD_waitrequest = 1'b1;
        if2.req = 2'b10;
        wait_write(2, seen);
        n_total++;
        if (!seen) begin $display("FAIL rst_timeout: no SD_write within 10 cycles"); return; end
        n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (if2.SD_write !== 1'b0 || if2.ack !== 2'b00 || if2.grant_idx !== 1'd1)
            $display("FAIL rst_async: write=%b ack=%b idx=%0d required 0/00/1", if2.SD_write, if2.ack, if2.grant_idx);
        else n_pass++;
        if2.req = '0;
        if2.SD_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            if (if2.ack !== 2'b00 || if2.SD_write !== 1'b0) acks++;
        end
        n_total++;
        if (acks != 0 || if2.grant_idx !== 1'd1)
            $display("FAIL rst_after: activity=%0d idx=%0d required 0/1", acks, if2.grant_idx);
        else n_pass++;
        last2 = 1; last3 = 2;
    endtask

    task automatic test_three();
        int exp;
        bit seen;
        for (int i = 0; i < 3; i++) begin
            if3.req_addr[i*28 +: 28] = 28'($urandom);
            if3.req_wdata[i*32 +: 32] = $urandom;
        end
        if3.SD_waitrequest = 1'b0;
        if3.req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            wait_write(3, seen);
            n_total++;
            if (!seen) begin $display("FAIL three_timeout: no SD_write within 10 cycles"); return; end
            n_pass++;
            exp = model_pick(last3, 7, 3);
            n_total++;
            if (int'(if3.grant_idx) != exp || if3.SD_address !== if3.req_addr[exp*28 +: 28] || if3.SD_wdata !== if3.req_wdata[exp*32 +: 32])
                $display("FAIL three_grant: transfer %0d got idx %0d required %0d", t, if3.grant_idx, exp);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (int'(if3.ack) != (1 << exp)) $display("FAIL three_ack: got %b required %0d", if3.ack, 1 << exp);
            else n_pass++;
            last3 = exp;
        end
        if3.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_no_regrant();
        int exp;
        bit seen;
        if2.SD_waitrequest = 1'b0;
        if2.req = 2'b01;
        wait_write(2, seen);
        n_total++;
        if (!seen) begin $display("FAIL hold_timeout: no SD_write within 10 cycles"); return; end
        n_pass++;
        exp = model_pick(last2, 1, 2);
        @(negedge clk);
        n_total++;
        if (if2.ack !== 2'b01) $display("FAIL hold_ack: got %b required 01", if2.ack);
        else n_pass++;
        last2 = exp;
        @(negedge clk);
        n_total++;
        if (if2.SD_write !== 1'b0 || if2.busy !== 1'b0)
            $display("FAIL hold_no_regrant: write=%b busy=%b required 0/0", if2.SD_write, if2.busy);
        else n_pass++;
        @(negedge clk);
        exp = model_pick(last2, 1, 2);
        n_total++;
        if (if2.SD_write !== 1'b1 || int'(if2.grant_idx) != exp)
            $display("FAIL hold_regrant: write=%b idx=%0d required 1/%0d", if2.SD_write, if2.grant_idx, exp);
        else n_pass++;
        @(negedge clk);
        if2.req = '0;
        last2 = exp;
        @(negedge clk);
    endtask

    task automatic test_random();
        int exp, mask, stall;
        bit seen;
        for (int n = 0; n < 25; n++) begin
            mask = $urandom_range(1, 3);
            stall = $urandom_range(0, 3);
            for (int i = 0; i < 2; i++) begin
                if2.req_addr[i*28 +: 28] = 28'($urandom);
                if2.req_wdata[i*32 +: 32] = $urandom;
            end
            if2.SD_waitrequest = (stall > 0);
            if2.req = 2'(mask);
            exp = model_pick(last2, mask, 2);
            wait_write(2, seen);
            n_total++;
            if (!seen) begin $display("FAIL rand_timeout: no SD_write within 10 cycles"); return; end
            n_pass++;
            n_total++;
            if (int'(if2.grant_idx) != exp || if2.SD_address !== if2.req_addr[exp*28 +: 28] || if2.SD_wdata !== if2.req_wdata[exp*32 +: 32])
                $display("FAIL rand_grant: iter %0d mask %0d got idx %0d required %0d", n, mask, if2.grant_idx, exp);
            else n_pass++;
            if ($urandom_range(0, 1) == 1) if2.req[exp] = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                n_total++;
                if (if2.SD_write !== 1'b1 || if2.SD_address !== if2.req_addr[exp*28 +: 28] || if2.ack !== 2'b00)
                    $display("FAIL rand_stall: iter %0d write=%b ack=%b required 1/00", n, if2.SD_write, if2.ack);
                else n_pass++;
            end
            if2.SD_waitrequest = 1'b0;
            @(negedge clk);
            n_total++;
            if (int'(if2.ack) != (1 << exp)) $display("FAIL rand_ack: iter %0d got %b required %0d", n, if2.ack, 1 << exp);
            else n_pass++;
            if2.req = '0;
            last2 = exp;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_reset_mid_write();
        test_three();
        test_ack_no_regrant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/sd_write_arbiter.md
# sd_write_arbiter

Shares the single SDRAM write port (SD_write/SD_wdata/SD_address/waitrequest) between several pixel write requesters. Typical requesters are the output controller's frame flush and a framebuffer clear engine. The block sits between those requesters and the top-level GPU SD_* ports. It grants one single-word write at a time, holds it on the bus until the slave accepts it, then acknowledges the winning requester.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester write request; held until ack
- req_addr  in  NUM_REQ*28  packed addresses, requester i at [28*i +: 28]
- req_wdata  in  NUM_REQ*32  packed data, requester i at [32*i +: 32]
- ack  out  NUM_REQ  one-cycle pulse, write of requester i completed
- grant_idx  out  IDX_W  index of the current/last granted requester
- busy  out  1  high in WRITE or ACK state
- SD_write  out  1  SDRAM write strobe
- SD_address  out  28  SDRAM word address
- SD_wdata  out  32  SDRAM write data
- SD_waitrequest  in  1  slave stall; write accepted in a cycle with SD_write=1 and SD_waitrequest=0

## Operation
- FSM states: IDLE, WRITE, ACK.
- IDLE: if any req bit is set, select the winner and register its addr/data into the SD_* outputs. Set SD_write=1, update grant_idx, and go to WRITE. Otherwise stay in IDLE.
- WRITE: hold SD_write, SD_address and SD_wdata stable. If SD_waitrequest=0, the write is accepted: clear SD_write, set ack[grant_idx]=1 and go to ACK. If SD_waitrequest=1, stay in WRITE indefinitely.
- ACK: ack is high for this cycle only. No arbitration happens in this cycle, because the acked requester may still hold req. Go to IDLE.
- Arbitration is round-robin. The search starts at last_grant+1 and wraps modulo NUM_REQ. last_grant updates only on entry to WRITE.
- Requester contract: req_addr and req_wdata are stable while req is high. Req is deasserted, or replaced with the next write, in the cycle after ack.
- Dropping req after grant does not abort the transfer; the write completes and is acked.
- Req bits of other requesters are ignored until IDLE.
- NUM_REQ not a power of two: the wrap skips indices >= NUM_REQ.

## Timing
- Reset values: SD_write=0, SD_address=0, SD_wdata=0, ack=0, busy=0, grant_idx=NUM_REQ-1 (so requester 0 wins first), state=IDLE.
- Latency: req sampled in IDLE at cycle N, SD_write=1 at N+1. With waitrequest=0 at N+1, ack pulses at N+2.
- Peak throughput: one write per 3 cycles. Each cycle of waitrequest=1 adds one cycle.
- All outputs are registered; no combinational path from req or waitrequest to outputs.
- Asserting reset mid-WRITE clears SD_write asynchronously. The in-flight write is dropped with no ack, and requesters must re-request.
- Simultaneous requests resolve in one cycle by the round-robin pointer; the losers wait, with no starvation.

## Configuration
- SD_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest index with req set always wins. The last_grant pointer is unused, and grant_idx still reports the winner.
- Undefined (default): round-robin as above.

## Structure
- Package sd_arb_pkg holds:
  - SD_ADDR_W=28 and SD_DATA_W=32;
  - the state enum arb_state_t {IDLE, WRITE, ACK}.
- Sub-module sd_rr_pick: combinational one-hot/index picker.
  - Inputs: req and last_grant.
  - Outputs: valid and winner index.
  - The SD_ARB_FIXED_PRIO_EN selection lives here.

## Test plan
- Reset, then req=2'b01 with addr 0x0000100 and data 0xDEADBEEF, waitrequest=0. Expect SD_write at N+1 with those values and ack=2'b01 at N+2. Busy falls at N+3.
- Both req high, each held for 4 transfers, waitrequest=0. Expect grants alternating 0,1,0,1 and SD_write with a 3-cycle period.
- Req0 with waitrequest=1 for 5 cycles. Expect SD_write, address and data stable for all 6 cycles, and ack exactly once, after the first waitrequest=0.
- Assert reset low during WRITE. Expect SD_write=0 immediately, no ack, and grant_idx=NUM_REQ-1 after release.
- NUM_REQ=3, all req high. Expect grant order 0,1,2,0. Under SD_ARB_FIXED_PRIO_EN, expect 0,0,0,0.
- Req0 acked while req0 stays high into the ACK cycle. Expect no second grant in ACK; the next grant comes only from IDLE.
